// File: rtl/muldiv_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage: 32-step shift-add
// multiply or restoring divide, pipeline stall while busy, one-cycle HI/LO write.
module muldiv_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [5:0]       ALUop,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1a;
    localparam logic [5:0] ALU_DIVU  = 6'h1b;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CW-1:0]      count;
    logic               op_div;
    logic               neg_pq;
    logic               neg_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    logic               valid_op;
    logic               is_div;
    logic               is_signed;
    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;

    always_comb begin
        valid_op  = (ALUop == ALU_MULT) || (ALUop == ALU_MULTU) ||
                    (ALUop == ALU_DIV)  || (ALUop == ALU_DIVU);
        is_div    = (ALUop == ALU_DIV)  || (ALUop == ALU_DIVU);
        is_signed = (ALUop == ALU_MULT) || (ALUop == ALU_DIV);
        abs_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        accept    = start && valid_op && (state == S_IDLE) && !flush;
        last_iter = (count == CW'(WIDTH - 1));
    end

    assign stall   = accept || (state == S_CALC);
    assign busy    = (state != S_IDLE);
    assign hilo_we = (state == S_DONE) && !flush;

    // acc holds {hi-half, lo-half}: {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, opnd};
        acc_nxt = {msum, acc[WIDTH-1:1]};
        if (op_div) begin
            if (rem_sh >= {1'b0, opnd})
                acc_nxt = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_pq ? -acc_nxt : acc_nxt;
        hi_fin   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fin   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            lo_fin = neg_pq ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
            hi_fin = neg_r ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            count  <= '0;
            op_div <= 1'b0;
            neg_pq <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_div <= is_div;
                neg_pq <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r  <= is_signed && src_a[WIDTH-1];
                acc    <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                opnd   <= is_div ? abs_b : abs_a;
                count  <= '0;
            end else if ((state == S_CALC) && !flush) begin
                acc <= acc_nxt;
                // Results land on entry to DONE so they are stable while hilo_we is high
                if (last_iter) begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed self-checking bench for muldiv_seq_ctrl: latency, stall window,
// signed/unsigned results, divide by zero, flush and asynchronous reset.
module tb_muldiv_seq_ctrl;

    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1a;
    localparam logic [5:0] ALU_DIVU  = 6'h1b;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [5:0]  ALUop;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int checks = 0;
    int errors = 0;

    muldiv_seq_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .ALUop   (ALUop),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .stall   (stall),
        .hilo_we (hilo_we),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, wait (bounded) for the write strobe, check timing and results
    task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        int st;
        ALUop = op;
        src_a = a;
        src_b = b;
        start = 1'b1;
        #1;
        chk({tag, "_accept_stall"}, 64'(stall), 64'(1));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        st  = 1;
        while (!hilo_we && cyc < 40) begin
            if (stall) st++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(33));
        chk({tag, "_stall_cycles"}, 64'(st), 64'(33));
        chk({tag, "_done_stall"}, 64'(stall), 64'(0));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
        chk({tag, "_we_after"}, 64'(hilo_we), 64'(0));
    endtask

    initial begin
        int cyc;
        int pulses;
        resetn = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        ALUop  = '0;
        src_a  = '0;
        src_b  = '0;

        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_we", 64'(hilo_we), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        resetn = 1'b1;
        @(negedge clk);

        do_op("multu_max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult_neg", ALU_MULT, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
        do_op("mult_minmin", ALU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        do_op("div_neg", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("divu_by0", ALU_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        do_op("div_by0", ALU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001);
        do_op("divu_bigdiv", ALU_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001);

        // Non-muldiv opcode must be ignored
        ALUop = 6'h00;
        start = 1'b1;
        #1;
        chk("badop_stall", 64'(stall), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("badop_busy", 64'(busy), 64'(0));

        // start together with flush is ignored
        ALUop = ALU_MULTU;
        flush = 1'b1;
        #1;
        chk("startflush_stall", 64'(stall), 64'(0));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("startflush_busy", 64'(busy), 64'(0));

        // Flush in CALC cycle 10
        ALUop = ALU_MULTU;
        src_a = 32'hFFFFFFFF;
        src_b = 32'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_stall", 64'(stall), 64'(0));
        chk("flush_we", 64'(hilo_we), 64'(0));
        chk("flush_hi_hold", 64'(hi), 64'(32'h7FFFFFFE));
        chk("flush_lo_hold", 64'(lo), 64'(32'h00000001));
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (hilo_we) pulses++;
        end
        chk("flush_no_pulse", 64'(pulses), 64'(0));
        do_op("multu_3_5", ALU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

        // Flush during DONE suppresses the strobe
        ALUop = ALU_MULTU;
        src_a = 32'd2;
        src_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!(busy && !stall) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("doneflush_reach", 64'(cyc), 64'(33));
        flush = 1'b1;
        #1;
        chk("doneflush_we", 64'(hilo_we), 64'(0));
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("doneflush_busy", 64'(busy), 64'(0));

        // Asynchronous reset mid-divide
        ALUop = ALU_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_stall", 64'(stall), 64'(0));
        chk("arst_we", 64'(hilo_we), 64'(0));
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("arst_idle", 64'(busy), 64'(0));

        // Back-to-back: second issued in the cycle right after DONE
        do_op("b2b_first", ALU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
        do_op("b2b_second", ALU_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
